// File: rtl/df_mac_sequencer_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package df_mac_sequencer_pkg;

   localparam int TAPS_DEF   = 4;
   localparam int DATA_W_DEF = 8;
   localparam int COEF_W_DEF = 3;

   // Encodings are shared with the filter top level, so they are pinned explicitly.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Sum of TAPS unsigned DATA_W products never exceeds this width.
   function automatic int acc_width(input int taps, input int data_w);
      return data_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/df_mac_sequencer_if.sv
// Bundles the sample, config, shared-multiplier and result ports of the sequencer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes.
// Ports: in_* sample stream, cfg_* coef writes, mul_* shared multiplier, out_* result, busy.
interface df_mac_sequencer_if
   import df_mac_sequencer_pkg::*;
#(
   parameter int TAPS   = TAPS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int COEF_W = COEF_W_DEF
);
   localparam int ACC_W = acc_width(TAPS, DATA_W);
   localparam int AW    = $clog2(TAPS);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              cfg_we;
   logic [AW-1:0]     cfg_addr;
   logic [COEF_W-1:0] cfg_coef;
   logic [COEF_W-1:0] mul_coef;
   logic [DATA_W-1:0] mul_data;
   logic [DATA_W-1:0] mul_out;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              busy;

   // Sequencer side.
   modport master (
      input  in_valid, in_data, cfg_we, cfg_addr, cfg_coef, mul_out, out_ready,
      output in_ready, mul_coef, mul_data, out_valid, out_data, busy
   );

   // Environment side: sample source, config, multiplier and output stage.
   modport slave (
      output in_valid, in_data, cfg_we, cfg_addr, cfg_coef, mul_out, out_ready,
      input  in_ready, mul_coef, mul_data, out_valid, out_data, busy
   );

endinterface

// File: rtl/df_delay_line.sv
// TAPS-deep sample shift register with a tap-indexed read mux.
// Latency: shift takes effect on the enabling edge; read is combinational.
// Backpressure: none; shifts whenever shift_en is high.
// Ports: clk, rst_n, shift_en, din (new x[0]), rd_idx (tap), rd_data (x[rd_idx]).
module df_delay_line #(
   parameter int TAPS   = 4,
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    shift_en,
   input  logic [DATA_W-1:0]       din,
   input  logic [$clog2(TAPS)-1:0] rd_idx,
   output logic [DATA_W-1:0]       rd_data
);

   logic [DATA_W-1:0] x [TAPS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) x[i] <= '0;
      end else if (shift_en) begin
         x[0] <= din;
         for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
      end
   end

   // TAPS is a power of two, so every rd_idx value addresses a real tap.
   assign rd_data = x[rd_idx];

endmodule

// File: rtl/df_mac_sequencer.sv
// FIR controller stepping one shared multiplier through all taps per sample.
// Latency: accept edge T, MAC on edges T+1..T+TAPS, out_valid from edge T+TAPS.
// Backpressure: out_ready low parks in DONE with in_ready low; nothing is dropped.
// Ports: clk, rst_n, bus (df_mac_sequencer_if.master).
module df_mac_sequencer
   import df_mac_sequencer_pkg::*;
#(
   parameter int TAPS   = TAPS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int COEF_W = COEF_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   df_mac_sequencer_if.master   bus
);

   localparam int ACC_W = acc_width(TAPS, DATA_W);
   localparam int AW    = $clog2(TAPS);
   localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

   state_t            state, state_nxt;
   logic [AW-1:0]     k;
   logic [ACC_W-1:0]  acc;
   logic [COEF_W-1:0] shadow [TAPS];
   logic [COEF_W-1:0] active [TAPS];
   logic [DATA_W-1:0] tap_data;
   logic              accept;

   logic              in_ready_c, out_valid_c, busy_c;
   logic [COEF_W-1:0] mul_coef_c;
   logic [DATA_W-1:0] mul_data_c;

   assign accept = (state == IDLE) && bus.in_valid;

   df_delay_line #(
      .TAPS   (TAPS),
      .DATA_W (DATA_W)
   ) u_delay_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (accept),
      .din      (bus.in_data),
      .rd_idx   (k),
      .rd_data  (tap_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Multiplier operands are forced to zero outside MAC so the shared
   // multiplier does not toggle on idle cycles.
   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      mul_coef_c  = '0;
      mul_data_c  = '0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = MAC;
         end
         MAC: begin
            busy_c     = 1'b1;
            mul_coef_c = active[k];
            mul_data_c = tap_data;
            if (k == K_LAST) state_nxt = DONE;
         end
         DONE: begin
            busy_c      = 1'b1;
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The active bank is latched from the old shadow value at acceptance, so a
   // cfg write in that same cycle only reaches the following sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         k   <= '0;
         acc <= '0;
      end else begin
         if (bus.cfg_we) shadow[bus.cfg_addr] <= bus.cfg_coef;
         if (accept) begin
            for (int i = 0; i < TAPS; i++) active[i] <= shadow[i];
            k   <= '0;
            acc <= '0;
         end else if (state == MAC) begin
            k   <= k + 1'b1;
            acc <= acc + ACC_W'(bus.mul_out);
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = acc;
   assign bus.busy      = busy_c;
   assign bus.mul_coef  = mul_coef_c;
   assign bus.mul_data  = mul_data_c;

endmodule

// File: tb/tb_df_mac_sequencer.sv
// Directed bench for df_mac_sequencer with a stub standing in for the shared multiplier.
// Stub modes: identity (product = data) and coef-order (product = coef select).
module tb_df_mac_sequencer;
   localparam int TAPS   = 4;
   localparam int DATA_W = 8;
   localparam int COEF_W = 3;

   logic clk;
   logic rst_n;
   logic stub_coef;
   int   total;
   int   bad;

   df_mac_sequencer_if #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

   df_mac_sequencer #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Combinational multiplier stub.
   assign bus.mul_out = stub_coef ? DATA_W'(bus.mul_coef) : bus.mul_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for in_ready, then presents d for one accepting edge.
   task automatic send(input logic [7:0] d);
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("in_ready_wait", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Waits (bounded) for the result, checks latency and value, then handshakes.
   task automatic collect(input string tag, input int exp_lat, input int exp);
      int n = 0;
      while (!bus.out_valid && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, exp_lat);
      chk(tag, bus.out_data, exp);
      tick();
      chk({tag, "_drop"}, bus.out_valid, 0);
   endtask

   task automatic cfg(input int addr, input int coef);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'(addr);
      bus.cfg_coef = 3'(coef);
      tick();
      bus.cfg_we   = 1'b0;
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      stub_coef     = 1'b0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_coef  = '0;
      bus.out_ready = 1'b1;

      // Reset state.
      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_mul_coef", bus.mul_coef, 0);
      chk("rst_mul_data", bus.mul_data, 0);
      chk("rst_out_data", bus.out_data, 0);
      rst_n = 1'b1;
      tick();

      // Identity stub: running sums of the delay line.
      send(8'd10);
      chk("mac_busy", bus.busy, 1);
      chk("mac_in_ready", bus.in_ready, 0);
      collect("id10", TAPS, 10);
      send(8'd20);
      collect("id20", TAPS, 30);
      send(8'd30);
      collect("id30", TAPS, 60);
      send(8'd40);
      collect("id40", TAPS, 100);

      // Coef-order stub: coefs 1..4 stepped in tap order, sum 10.
      stub_coef = 1'b1;
      cfg(0, 1);
      cfg(1, 2);
      cfg(2, 3);
      cfg(3, 4);
      send(8'd50);
      chk("ord_data0", bus.mul_data, 50);
      for (int i = 0; i < TAPS; i++) begin
         chk($sformatf("ord_coef%0d", i), bus.mul_coef, i + 1);
         tick();
      end
      chk("ord_done", bus.out_valid, 1);
      collect("ord_res", 0, 10);

      // Write during MAC does not touch the result in flight.
      send(8'd60);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'd0;
      bus.cfg_coef = 3'd7;
      chk("iso_coef0_old", bus.mul_coef, 1);
      tick();
      bus.cfg_we = 1'b0;
      collect("iso_inflight", TAPS - 1, 10);
      send(8'd70);
      chk("iso_coef0_new", bus.mul_coef, 7);
      collect("iso_next", TAPS, 16);

      // Write in the acceptance cycle is deferred to the next sample.
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'd1;
      bus.cfg_coef = 3'd0;
      send(8'd80);
      bus.cfg_we = 1'b0;
      collect("acc_wr_same", TAPS, 16);
      send(8'd90);
      collect("acc_wr_next", TAPS, 14);

      // Backpressure: delay line becomes 100,90,80,70 -> 340; 110 waits.
      stub_coef     = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'd100;
      tick();
      bus.in_data = 8'd110;
      begin
         int n = 0;
         while (!bus.out_valid && n < 50) begin
            tick();
            n++;
         end
         chk("bp_lat", n, TAPS);
      end
      for (int i = 0; i < 20; i++) begin
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_data", bus.out_data, 340);
         chk("bp_in_ready", bus.in_ready, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      chk("bp_release_data", bus.out_data, 340);
      tick();
      chk("bp_one_hs_valid", bus.out_valid, 0);
      chk("bp_idle_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_next_busy", bus.busy, 1);
      collect("bp_next", TAPS, 380);

      // Reset at k=2 of a MAC pass.
      send(8'd120);
      tick();
      tick();
      chk("mid_busy_pre", bus.busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_busy", bus.busy, 0);
      chk("mid_in_ready", bus.in_ready, 1);
      chk("mid_mul_data", bus.mul_data, 0);
      chk("mid_out_data", bus.out_data, 0);
      tick();
      chk("mid_out_valid", bus.out_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      send(8'd5);
      collect("mid_after", TAPS, 5);
      // Coef banks were cleared by the reset, so every product is zero.
      stub_coef = 1'b1;
      send(8'd6);
      collect("mid_coef_clr", TAPS, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
